uart_rx_buf: RTL and testbench
==============================

Name: uart_rx_buf

Overview:
UART 8N1 receiver. It is the receiving end of the serial line that the string transmitters (scicad-style) drive.
- Synchronises the asynchronous rx pin, detects and validates the start bit, and samples 8 data bits LSB first at mid-bit.
- Checks the stop bit and presents each byte in a one-entry holding register with a valid/ack handshake.
- Reports framing errors and overruns.
- Sits between the FPGA rx pin and user logic such as an echo unit, LED display or command parser.

Parameters:
BAUD, 104 (`B115200 from baudgen.vh at 12 MHz), clock cycles per bit; legal range 16..65535.

Ports:
clk     in   1  system clock; the only clock.
rst     in   1  reset; synchronous, active-high.
rx      in   1  serial line from pin; idles high; asynchronous to clk.
data    out  8  last correctly received byte.
valid   out  1  data holds an unconsumed byte.
ack     in   1  consumer takes data; clears valid.
rcv     out  1  one-cycle pulse when a good byte lands in data.
ferr    out  1  one-cycle pulse when the stop bit is sampled 0.
ovr     out  1  sticky overrun flag.
busy    out  1  high while a frame is in progress (any state but IDLE).

Behaviour:
- Reset: data=0x00, valid=0, rcv=0, ferr=0, ovr=0, busy=0, FSM=IDLE, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame. Nothing is written, and the FSM restarts in IDLE.
- Synchroniser: 2 flops on rx. rxs is the second flop. All logic uses rxs only.
- Bit timer: counter from 0 to BAUD-1.
  - It is cleared on entry to START.
  - It pulses tick once when the count reaches BAUD/2-1 (integer division) in START.
  - It pulses tick every BAUD cycles in DATA and STOP.
- FSM:
  - IDLE: on rxs==0 go to START and clear the timer. That cycle is t0.
  - START: at tick (t0+BAUD/2), if rxs==0 go to DATA with bit index 0. If rxs==1 it was a glitch: return to IDLE with no outputs.
  - DATA: at each tick, shift rxs into bit [idx] (LSB first) and increment idx. After idx 7 go to STOP.
  - STOP: at tick (t0+BAUD/2+9·BAUD), sample rxs.
    - If 1: it is a good frame. Go to IDLE.
    - If 0: pulse ferr for one cycle. data and valid are unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then go to IDLE. This prevents a break or low line from re-triggering continuously.
- Good-frame completion, on the cycle after the stop sample:
  - data = shift register, rcv=1 for one cycle, valid=1.
  - If valid was already 1 and ack is not asserted in that cycle, set ovr=1. The new byte still overwrites data (latest wins).
- Handshake:
  - ack while valid=1 clears valid and ovr on the next edge.
  - ack while valid=0 has no effect.
  - ack in the same cycle as a completion: the old byte is consumed, the new byte loads, valid stays 1, and ovr is not set.
- Back-to-back frames: IDLE re-arms at mid stop bit. A start edge arriving as early as half a bit after the stop sample must be caught.
- Latency: from the rx pin falling edge of the start bit to rcv = 2 (synchroniser) + 1 + BAUD/2 + 9·BAUD + 1 cycles.
- Widths: the timer counter is $clog2(BAUD) bits and idx is 3 bits. No arithmetic is wider than the counter.

Decomposition:
- Shared header (baudgen.vh): baud-rate constants (`B115200, `B9600, …) and FSM state encodings (IDLE, START, DATA, STOP, WAIT_IDLE), shared with future receivers.
- One sub-module: baudgen_rx (BAUD).
  - Inputs clk, rst and clr_n (run enable).
  - Output tick: first tick at BAUD/2 after run starts, then every BAUD cycles.
  - It is the receive counterpart of the transmitter's baudgen.
- The top instantiates baudgen_rx, the synchroniser, the FSM and the holding register.

Test Plan:
- Reset check: hold rst 5 cycles with rx=1 → all outputs 0; busy=0; no rcv for 20·BAUD cycles of idle line.
- Single byte: drive 0x55 ('U') at BAUD=104 → exactly one rcv pulse at the computed latency; data=0x55; valid=1; ferr=0; ovr=0. Repeat with 0x00 and 0xFF.
- Glitch: rx low for BAUD/4 cycles, then high → no rcv, no ferr; FSM back in IDLE with busy=0 before BAUD/2+4 cycles.
- Framing error: send 0xA3 with the stop bit forced 0, then rx low 3·BAUD → one ferr pulse; valid and data unchanged; no new frame until rx returns high.
- Overrun and handshake: send 'H' then 'o' back to back with no ack → data='o', valid=1, ovr=1. Pulse ack → valid=0 and ovr=0 next cycle. Then send 'l' with ack coincident with rcv → valid=1, ovr=0.
- Reset mid-frame and loopback: assert rst during bit 4 of a frame → no rcv, clean restart. Then loop a scicad1 instance's tx into rx (BAUD matched, dtr pulse) → the received byte sequence equals the transmitted string exactly, with ferr never pulsing.

Source files
------------

// File: rtl/uart_rx_buf_pkg.sv
// Shared constants for the serial receivers: clocks-per-bit at a 12 MHz system
// clock and the receive FSM state encoding.
package uart_rx_buf_pkg;

    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B38400  = 313;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B9600   = 1250;
    localparam int unsigned B4800   = 2500;
    localparam int unsigned B2400   = 5000;
    localparam int unsigned B1200   = 10000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned baud);
        return baud / 2;
    endfunction

endpackage

// File: rtl/uart_rx_buf_baudgen_rx.sv
// Receive bit timer: while run (clr_n) is high, ticks first at half a bit, then
// once per bit. Dropping clr_n re-arms it for the next start bit.
module uart_rx_buf_baudgen_rx
    import uart_rx_buf_pkg::*;
#(
    parameter int unsigned BAUD = B115200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_n,
    output logic tick
);

    localparam int unsigned W = $clog2(BAUD);
    localparam logic [W-1:0] HALF_M1 = W'(half_bit(BAUD) - 1);
    localparam logic [W-1:0] FULL_M1 = W'(BAUD - 1);

    logic [W-1:0] cnt;

    // Down-counter with terminal count at zero; the preload while idle sets the
    // half-bit phase so the first tick lands mid start bit.
    always_ff @(posedge clk) begin
        if (rst || !clr_n) begin
            cnt <= HALF_M1;
        end else if (cnt == '0) begin
            cnt <= FULL_M1;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = clr_n && (cnt == '0);

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a one-entry holding register, valid/ack handshake,
// framing-error pulse and sticky overrun flag.
//
// state     | meaning
// IDLE      | line idle, waiting for a low on rxs
// START     | timing to mid start bit to reject glitches
// DATA      | sampling 8 data bits LSB first at mid-bit
// STOP      | waiting for mid stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_buf
    import uart_rx_buf_pkg::*;
#(
    parameter int unsigned BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       rcv,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    logic      rx_meta;
    logic      rxs;
    rx_state_t state;
    rx_state_t state_nxt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic      run;
    logic      tick;
    logic      done;
    logic      done_nxt;
    logic      ferr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign run = (state == START) || (state == DATA) || (state == STOP);

    uart_rx_buf_baudgen_rx #(
        .BAUD (BAUD)
    ) u_baudgen (
        .clk   (clk),
        .rst   (rst),
        .clr_n (run),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (tick) state_nxt = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && (idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (rxs) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT_IDLE;
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 3'd0;
            shreg <= 8'h00;
            done  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            done <= done_nxt;
            ferr <= ferr_nxt;
            if (state == START) begin
                idx <= 3'd0;
            end else if ((state == DATA) && tick) begin
                shreg[idx] <= rxs;
                idx        <= idx + 3'd1;
            end
        end
    end

    // Holding register. A completion coinciding with ack consumes the old byte,
    // so it is not an overrun; otherwise the newest byte always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= 8'h00;
            valid <= 1'b0;
            rcv   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            rcv <= done;
            if (done) begin
                data  <= shreg;
                valid <= 1'b1;
                if (valid && !ack) begin
                    ovr <= 1'b1;
                end else if (valid && ack) begin
                    ovr <= 1'b0;
                end
            end else if (ack && valid) begin
                valid <= 1'b0;
                ovr   <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf: table of single frames plus directed sequences for
// glitches, overrun/handshake, reset mid-frame and a back-to-back string.
module tb_uart_rx_buf;

    localparam int BAUD = 104;
    localparam int LAT  = 2 + 1 + BAUD / 2 + 9 * BAUD + 1;
    localparam int SHORT_STOP = BAUD / 2 + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       rcv;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rcv_cnt = 0;
    int ferr_cnt = 0;
    int last_rcv_cyc = 0;
    int fall_cyc = 0;
    int r0, f0, c0, qn;
    logic [7:0] rxq[$];
    string msg;

    typedef struct {
        logic [7:0] val;
        logic       stopb;
        logic       ack_before;
        int         exp_rcv;
        int         exp_ferr;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    uart_rx_buf #(
        .BAUD (BAUD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .data  (data),
        .valid (valid),
        .ack   (ack),
        .rcv   (rcv),
        .ferr  (ferr),
        .ovr   (ovr),
        .busy  (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rcv === 1'b1) begin
            rcv_cnt      <= rcv_cnt + 1;
            last_rcv_cyc <= cyc;
            rxq.push_back(data);
        end
        if (ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick_n(1);
        ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stopb, input int stop_len);
        rx = 1'b0;
        fall_cyc = cyc;
        tick_n(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            tick_n(BAUD);
        end
        rx = stopb;
        tick_n(stop_len);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [7:0] mf;

        tbl[0] = '{8'h55, 1'b1, 1'b0, 1, 0, 8'h55, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'hA3, 1'b0, 1'b0, 0, 1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h3C, 1'b1, 1'b0, 1, 0, 8'h3C, 1'b1, 1'b1};

        // Reset and idle line
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_rcv", rcv, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        tick_n(20 * BAUD);
        chk("idle_rcv_cnt", rcv_cnt, 0);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].ack_before) pulse_ack();
            r0 = rcv_cnt;
            f0 = ferr_cnt;
            send_frame(tbl[i].val, tbl[i].stopb, BAUD);
            if (!tbl[i].stopb) begin
                tick_n(3 * BAUD);
                msg = $sformatf("v%0d_wait_busy", i);
                chk(msg, busy, 1);
                msg = $sformatf("v%0d_wait_rcv", i);
                chk(msg, rcv_cnt - r0, 0);
                rx = 1'b1;
                tick_n(6);
                msg = $sformatf("v%0d_release_busy", i);
                chk(msg, busy, 0);
            end
            tick_n(4);
            msg = $sformatf("v%0d_rcv", i);
            chk(msg, rcv_cnt - r0, tbl[i].exp_rcv);
            msg = $sformatf("v%0d_ferr", i);
            chk(msg, ferr_cnt - f0, tbl[i].exp_ferr);
            msg = $sformatf("v%0d_data", i);
            chk(msg, data, tbl[i].exp_data);
            msg = $sformatf("v%0d_valid", i);
            chk(msg, valid, tbl[i].exp_valid);
            msg = $sformatf("v%0d_ovr", i);
            chk(msg, ovr, tbl[i].exp_ovr);
            if (tbl[i].exp_rcv == 1) begin
                msg = $sformatf("v%0d_latency", i);
                chk(msg, last_rcv_cyc - fall_cyc, LAT);
            end
        end

        // ack clears valid and sticky overrun; ack with valid low does nothing
        pulse_ack();
        chk("ack_valid", valid, 0);
        chk("ack_ovr", ovr, 0);
        pulse_ack();
        chk("ack_idle_valid", valid, 0);
        chk("ack_idle_data", data, 8'h3C);

        // Back-to-back overrun with a short stop bit
        r0 = rcv_cnt;
        send_frame("H", 1'b1, SHORT_STOP);
        send_frame("o", 1'b1, BAUD);
        tick_n(4);
        chk("b2b_rcv", rcv_cnt - r0, 2);
        chk("b2b_data", data, "o");
        chk("b2b_valid", valid, 1);
        chk("b2b_ovr", ovr, 1);
        pulse_ack();
        chk("b2b_ack_valid", valid, 0);
        chk("b2b_ack_ovr", ovr, 0);

        // ack coincident with completion: old byte consumed, new one held
        send_frame("e", 1'b1, BAUD);
        tick_n(4);
        chk("pre_coin_valid", valid, 1);
        r0 = rcv_cnt;
        c0 = cyc;
        fork
            send_frame("l", 1'b1, BAUD);
            begin
                tick_n(LAT - 1);
                ack = 1'b1;
                tick_n(1);
                ack = 1'b0;
            end
        join
        tick_n(4);
        chk("coin_rcv", rcv_cnt - r0, 1);
        chk("coin_rcv_cyc", last_rcv_cyc - c0, LAT);
        chk("coin_data", data, "l");
        chk("coin_valid", valid, 1);
        chk("coin_ovr", ovr, 0);

        // Start-bit glitch
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick_n(10);
        chk("glitch_busy_hi", busy, 1);
        tick_n(BAUD / 4 - 10);
        rx = 1'b1;
        tick_n(BAUD / 2 + 4 - BAUD / 4);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_rcv", rcv_cnt - r0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // Reset during data bit 4
        r0 = rcv_cnt;
        mf = 8'hC3;
        rx = 1'b0;
        tick_n(BAUD);
        for (int i = 0; i < 4; i++) begin
            rx = mf[i];
            tick_n(BAUD);
        end
        rx = mf[4];
        tick_n(BAUD / 2);
        rst = 1'b1;
        tick_n(3);
        rx = 1'b1;
        rst = 1'b0;
        tick_n(2 * BAUD);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_rcv", rcv_cnt - r0, 0);
        send_frame(8'h5A, 1'b1, BAUD);
        tick_n(4);
        chk("postrst_rcv", rcv_cnt - r0, 1);
        chk("postrst_data", data, 8'h5A);

        // Back-to-back string, minimal stop bits
        s = "Hello, uart!";
        qn = rxq.size();
        f0 = ferr_cnt;
        for (int k = 0; k < s.len(); k++) begin
            send_frame(s[k], 1'b1, SHORT_STOP);
        end
        tick_n(BAUD);
        chk("loop_count", rxq.size() - qn, s.len());
        chk("loop_ferr", ferr_cnt - f0, 0);
        for (int k = 0; k < s.len(); k++) begin
            if (qn + k < rxq.size()) begin
                msg = $sformatf("loop_byte%0d", k);
                chk(msg, rxq[qn + k], s[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
